// File: rtl/cpu_controller.sv
// cpu_controller: fetch/decode/execute sequencer for the 16-bit datapath.
// Decodes the instruction register and drives datapath and memory controls.
// All controls except the sign-extended immediates are registered; they are
// computed from the state being entered, so ir must stay stable while an
// instruction runs. The top level only loads ir in IF2, so this holds.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [1:0]  mem_cmd,
    output logic        addr_sel,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_ir,
    output logic        load_addr,
    output logic        halt
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DEC,
        S_WIMM,
        S_GB_MV, S_EX_MOV, S_EX_MVN, S_WR,
        S_GA_ALU, S_GB_ALU, S_EX_ALU, S_EXS,
        S_GA_MEM, S_ADR, S_LA, S_MRD, S_WBM, S_GBS, S_PASS, S_MWR,
        S_HALT
    } state_t;

    state_t state;
    state_t nxt;
    state_t tgt;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    logic [2:0] readnum_c, writenum_c;
    logic [3:0] vsel_c;
    logic       loada_c, loadb_c, loadc_c, loads_c, write_c, asel_c, bsel_c;
    logic [1:0] shift_c, alu_op_c, mem_cmd_c;
    logic       addr_sel_c, load_pc_c, reset_pc_c, load_ir_c, load_addr_c, halt_c;

    // Next-state sequencing and instruction dispatch
    always_comb begin
        nxt = S_IF1;
        case (state)
            S_RST:    nxt = S_IF1;
            S_IF1:    nxt = S_IF2;
            S_IF2:    nxt = S_UPD;
            S_UPD:    nxt = S_DEC;
            S_DEC: begin
                case ({opcode, op})
                    5'b11010:           nxt = S_WIMM;
                    5'b11000, 5'b10111: nxt = S_GB_MV;
                    5'b10100, 5'b10101,
                    5'b10110:           nxt = S_GA_ALU;
                    5'b01100, 5'b10000: nxt = S_GA_MEM;
                    default:            nxt = (opcode == 3'b111) ? S_HALT : S_IF1;
                endcase
            end
            S_GB_MV:  nxt = (opcode == 3'b101) ? S_EX_MVN : S_EX_MOV;
            S_EX_MOV: nxt = S_WR;
            S_EX_MVN: nxt = S_WR;
            S_GA_ALU: nxt = S_GB_ALU;
            S_GB_ALU: nxt = (op == 2'b01) ? S_EXS : S_EX_ALU;
            S_EX_ALU: nxt = S_WR;
            S_GA_MEM: nxt = S_ADR;
            S_ADR:    nxt = S_LA;
            S_LA:     nxt = (opcode == 3'b011) ? S_MRD : S_GBS;
            S_MRD:    nxt = S_WBM;
            S_GBS:    nxt = S_PASS;
            S_PASS:   nxt = S_MWR;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IF1;
        endcase
        tgt = reset ? S_RST : nxt;
    end

    // Control decode for the state about to be entered
    always_comb begin
        readnum_c   = 3'd0;
        writenum_c  = 3'd0;
        vsel_c      = 4'b0000;
        loada_c     = 1'b0;
        loadb_c     = 1'b0;
        loadc_c     = 1'b0;
        loads_c     = 1'b0;
        write_c     = 1'b0;
        asel_c      = 1'b0;
        bsel_c      = 1'b0;
        shift_c     = 2'b00;
        alu_op_c    = 2'b00;
        mem_cmd_c   = 2'b00;
        addr_sel_c  = 1'b0;
        load_pc_c   = 1'b0;
        reset_pc_c  = 1'b0;
        load_ir_c   = 1'b0;
        load_addr_c = 1'b0;
        halt_c      = 1'b0;
        case (tgt)
            S_RST:    begin reset_pc_c = 1'b1; load_pc_c = 1'b1; end
            S_IF1:    begin addr_sel_c = 1'b1; mem_cmd_c = 2'b01; end
            S_IF2:    begin addr_sel_c = 1'b1; mem_cmd_c = 2'b01; load_ir_c = 1'b1; end
            S_UPD:    load_pc_c = 1'b1;
            S_WIMM:   begin vsel_c = 4'b0100; writenum_c = rn; write_c = 1'b1; end
            S_GB_MV,
            S_GB_ALU: begin readnum_c = rm; loadb_c = 1'b1; end
            S_EX_MOV: begin shift_c = sh; asel_c = 1'b1; loadc_c = 1'b1; end
            S_EX_MVN: begin shift_c = sh; alu_op_c = 2'b11; loadc_c = 1'b1; end
            S_EX_ALU: begin shift_c = sh; alu_op_c = op; loadc_c = 1'b1; end
            S_EXS:    begin shift_c = sh; alu_op_c = 2'b01; loads_c = 1'b1; end
            S_WR:     begin vsel_c = 4'b0001; writenum_c = rd; write_c = 1'b1; end
            S_GA_ALU,
            S_GA_MEM: begin readnum_c = rn; loada_c = 1'b1; end
            S_ADR:    begin bsel_c = 1'b1; loadc_c = 1'b1; end
            S_LA:     load_addr_c = 1'b1;
            S_MRD:    mem_cmd_c = 2'b01;
            S_WBM:    begin
                mem_cmd_c  = 2'b01;
                vsel_c     = 4'b1000;
                writenum_c = rd;
                write_c    = 1'b1;
            end
            S_GBS:    begin readnum_c = rd; loadb_c = 1'b1; end
            S_PASS:   begin asel_c = 1'b1; loadc_c = 1'b1; end
            S_MWR:    mem_cmd_c = 2'b10;
            S_HALT:   halt_c = 1'b1;
            default:  ;
        endcase
    end

    // State register and registered controls
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
        end else begin
            state <= nxt;
        end
        readnum   <= readnum_c;
        writenum  <= writenum_c;
        vsel      <= vsel_c;
        loada     <= loada_c;
        loadb     <= loadb_c;
        loadc     <= loadc_c;
        loads     <= loads_c;
        write     <= write_c;
        asel      <= asel_c;
        bsel      <= bsel_c;
        shift     <= shift_c;
        ALUop     <= alu_op_c;
        mem_cmd   <= mem_cmd_c;
        addr_sel  <= addr_sel_c;
        load_pc   <= load_pc_c;
        reset_pc  <= reset_pc_c;
        load_ir   <= load_ir_c;
        load_addr <= load_addr_c;
        halt      <= halt_c;
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: scoreboard bench for cpu_controller.
// The stimulus side expands each instruction into its expected per-cycle
// control words and queues them; the monitor compares one word per cycle.
module tb_cpu_controller;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       load_ir;
        logic       load_addr;
        logic       halt;
    } ctl_t;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, alu_op, mem_cmd;
    logic [15:0] sximm8, sximm5;
    logic        addr_sel, load_pc, reset_pc, load_ir, load_addr, halt;

    cpu_controller dut (
        .clk(clk), .reset(reset), .ir(ir),
        .readnum(readnum), .writenum(writenum), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .write(write), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(alu_op),
        .sximm8(sximm8), .sximm5(sximm5),
        .mem_cmd(mem_cmd), .addr_sel(addr_sel),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_ir(load_ir),
        .load_addr(load_addr), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctl_t  exp_q[$];
    string nm_q[$];
    ctl_t  plan_c[$];
    string plan_n[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic ctl_t z();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic void add(input string n, input ctl_t c);
        plan_c.push_back(c);
        plan_n.push_back(n);
    endfunction

    // Expected per-cycle control words for one instruction, IF1 onward
    task automatic plan_instr(input logic [15:0] i);
        logic [2:0] opc = i[15:13];
        logic [1:0] op  = i[12:11];
        logic [2:0] rn  = i[10:8];
        logic [2:0] rd  = i[7:5];
        logic [1:0] sh  = i[4:3];
        logic [2:0] rm  = i[2:0];
        ctl_t c;
        plan_c.delete();
        plan_n.delete();
        c = z(); c.addr_sel = 1; c.mem_cmd = 2'b01; add("IF1", c);
        c.load_ir = 1; add("IF2", c);
        c = z(); c.load_pc = 1; add("UPD", c);
        c = z(); add("DEC", c);
        case ({opc, op})
            5'b11010: begin
                c = z(); c.vsel = 4'b0100; c.writenum = rn; c.write = 1; add("WIMM", c);
            end
            5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101: begin
                if (opc == 3'b101 && op != 2'b11) begin
                    c = z(); c.readnum = rn; c.loada = 1; add("GA", c);
                end
                c = z(); c.readnum = rm; c.loadb = 1; add("GB", c);
                c = z(); c.shift = sh;
                if (opc == 3'b110) begin
                    c.asel = 1; c.loadc = 1; add("EX_MOV", c);
                end else if (op == 2'b11) begin
                    c.alu_op = 2'b11; c.loadc = 1; add("EX_MVN", c);
                end else if (op == 2'b01) begin
                    c.alu_op = 2'b01; c.loads = 1; add("EXS", c);
                end else begin
                    c.alu_op = op; c.loadc = 1; add("EX_ALU", c);
                end
                if (!(opc == 3'b101 && op == 2'b01)) begin
                    c = z(); c.vsel = 4'b0001; c.writenum = rd; c.write = 1; add("WR", c);
                end
            end
            5'b01100, 5'b10000: begin
                c = z(); c.readnum = rn; c.loada = 1; add("GA", c);
                c = z(); c.bsel = 1; c.loadc = 1; add("ADR", c);
                c = z(); c.load_addr = 1; add("LA", c);
                if (opc == 3'b011) begin
                    c = z(); c.mem_cmd = 2'b01; add("MRD", c);
                    c.vsel = 4'b1000; c.writenum = rd; c.write = 1; add("WBM", c);
                end else begin
                    c = z(); c.readnum = rd; c.loadb = 1; add("GBS", c);
                    c = z(); c.asel = 1; c.loadc = 1; add("PASS", c);
                    c = z(); c.mem_cmd = 2'b10; add("MWR", c);
                end
            end
            default: begin
                if (opc == 3'b111) begin
                    c = z(); c.halt = 1; add("HALT", c);
                end
            end
        endcase
    endtask

    function automatic ctl_t rst_word();
        ctl_t c = '0;
        c.reset_pc = 1;
        c.load_pc  = 1;
        return c;
    endfunction

    // Drive reset for the next edge, then queue what that edge should produce
    task automatic step(input logic r, input string n, input ctl_t c);
        reset = r;
        @(posedge clk);
        exp_q.push_back(c);
        nm_q.push_back(n);
        #1;
    endtask

    // abort_at < 0: run to completion; halt_len: extra HALT cycles before reset
    task automatic run_instr(input logic [15:0] i, input int abort_at, input int halt_len);
        ctl_t h;
        plan_instr(i);
        for (int j = 0; j < plan_c.size(); j++) begin
            if (j == abort_at) begin
                step(1'b1, "RST", rst_word());
                step(1'b1, "RST", rst_word());
                return;
            end
            if (j == 2) ir = i;
            step(1'b0, plan_n[j], plan_c[j]);
        end
        if (i[15:13] == 3'b111) begin
            h = z(); h.halt = 1;
            for (int k = 0; k < halt_len; k++) step(1'b0, "HALT", h);
            step(1'b1, "RST", rst_word());
        end
    endtask

    // Monitor: one queued word per cycle, immediates checked against ir
    initial begin
        ctl_t act, e;
        string n;
        logic [15:0] e8, e5;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                act = '{readnum, writenum, vsel, loada, loadb, loadc, loads, write,
                        asel, bsel, shift, alu_op, mem_cmd, addr_sel, load_pc,
                        reset_pc, load_ir, load_addr, halt};
                e8 = {{8{ir[7]}}, ir[7:0]};
                e5 = {{11{ir[4]}}, ir[4:0]};
                vectors++;
                if (act !== e || sximm8 !== e8 || sximm5 !== e5) begin
                    miscompares++;
                    $display("FAIL %s ir=%h: ctl got %h want %h, sximm8 got %h want %h, sximm5 got %h want %h",
                             n, ir, act, e, sximm8, e8, sximm5, e5);
                end
            end
        end
    end

    // Stimulus: directed test-plan instructions, then random traffic
    initial begin
        logic [15:0] i;
        int          sel;
        int          ab;
        reset = 1'b1;
        ir    = 16'h0000;
        @(posedge clk);
        #1;
        step(1'b1, "RST", rst_word());
        step(1'b1, "RST", rst_word());
        run_instr(16'hD107, -1, 0);
        run_instr(16'hA148, -1, 0);
        run_instr(16'hA900, -1, 0);
        run_instr(16'h617F, -1, 0);
        run_instr(16'h8162, -1, 0);
        run_instr(16'h8162, 9, 0);
        run_instr(16'h8162, 5, 0);
        run_instr(16'hE000, -1, 20);
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 9));
            i = 16'($urandom);
            case (sel)
                0: i[15:11] = 5'b11010;
                1: i[15:11] = 5'b11000;
                2: i[15:11] = 5'b10111;
                3: i[15:11] = 5'b10100;
                4: i[15:11] = 5'b10110;
                5: i[15:11] = 5'b10101;
                6: i[15:11] = 5'b01100;
                7: i[15:11] = 5'b10000;
                8: if (i[15:13] == 3'b111) i[15:13] = 3'b000;
                default: if (($urandom & 32'd3) != 0) i[15:11] = 5'b00101;
            endcase
            plan_instr(i);
            ab = -1;
            if (plan_c.size() > 4 && ($urandom_range(0, 9) == 0))
                ab = int'($urandom_range(4, 32'(plan_c.size() - 1)));
            run_instr(i, ab, int'($urandom_range(1, 4)));
        end
        for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d queued words left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
